// File: rtl/rush3d_csr_slave_if.sv
// Avalon-MM slave bus bundle for the Rush3D control/status register block.
// The master modport is the host/bus side and the slave modport is the CSR block.
interface rush3d_csr_slave_if #(
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        output avs_byteenable,
        input  avs_readdata,
        input  avs_readdatavalid
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        input  avs_byteenable,
        output avs_readdata,
        output avs_readdatavalid
    );
endinterface

// File: rtl/rush3d_csr_slave.sv
// Host-facing CSR block holding the 64-bit Rush3D command word, the controller clear-back path,
// the pipeline status view, the buffer-swap frame counter and a maskable completion IRQ.
module rush3d_csr_slave #(
    parameter int unsigned ADDR_W   = 3,
    parameter logic [63:0] CMD_MASK = 64'h0000_0000_0000_0111
) (
    input  logic                     clock,
    input  logic                     reset_n,
    rush3d_csr_slave_if.slave        avs,
    output logic [63:0]              control_status_out,
    input  logic [63:0]              control_status_in,
    input  logic                     control_status_load,
    input  logic                     current_buffer_flag,
    input  logic [3:0]               framebuffer_write_state,
    input  logic                     pixel_fifo_empty,
    input  logic                     vertex_data_fifo_empty,
    output logic                     irq
);
    localparam logic [ADDR_W-1:0] AddrCtrlLo  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrCtrlHi  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrStatus  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] AddrIrqPend = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] AddrIrqEn   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] AddrFrame   = ADDR_W'(5);

    logic [63:0] ctrl_q, ctrl_d, ctrl_ld, wmask, wdata64, fall;
    logic [2:0]  pend_q, pend_d, en_q, en_d, w1c;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        buf_q;
    logic        irq_q;
    logic [31:0] readdata_q, rd_mux;
    logic        readdatavalid_q;
    logic [31:0] be_mask;
    logic        do_read;

    assign be_mask = {{8{avs.avs_byteenable[3]}}, {8{avs.avs_byteenable[2]}},
                      {8{avs.avs_byteenable[1]}}, {8{avs.avs_byteenable[0]}}};
    assign wdata64 = {avs.avs_writedata, avs.avs_writedata};
    assign do_read = avs.avs_read && !avs.avs_write;

    always_comb begin
        wmask = '0;
        if (avs.avs_write && avs.avs_address == AddrCtrlLo) wmask[31:0]  = be_mask;
        if (avs.avs_write && avs.avs_address == AddrCtrlHi) wmask[63:32] = be_mask;
    end

    // Load may only clear command bits; host data bits never see the controller value.
    always_comb begin
        ctrl_ld = ctrl_q;
        if (control_status_load) ctrl_ld = ctrl_q & (control_status_in | ~CMD_MASK);
        // Command bits OR in (set wins over a same-cycle clear); data bits are replaced.
        ctrl_d = (ctrl_ld & ~(wmask & ~CMD_MASK)) | (wdata64 & wmask);
    end

    assign fall = ctrl_q & ~ctrl_d & CMD_MASK;

    always_comb begin
        w1c = '0;
        if (avs.avs_write && avs.avs_address == AddrIrqPend && avs.avs_byteenable[0]) begin
            w1c = avs.avs_writedata[2:0];
        end
        pend_d = (pend_q & ~w1c) | {fall[8], fall[4], fall[0]};
        en_d   = en_q;
        if (avs.avs_write && avs.avs_address == AddrIrqEn && avs.avs_byteenable[0]) begin
            en_d = avs.avs_writedata[2:0];
        end
        frame_cnt_d = frame_cnt_q;
        if (buf_q != current_buffer_flag) frame_cnt_d = frame_cnt_q + 32'd1;
    end

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            AddrCtrlLo:  rd_mux = ctrl_q[31:0];
            AddrCtrlHi:  rd_mux = ctrl_q[63:32];
            AddrStatus:  rd_mux = {25'b0, framebuffer_write_state, vertex_data_fifo_empty,
                                   pixel_fifo_empty, current_buffer_flag};
            AddrIrqPend: rd_mux = {29'b0, pend_q};
            AddrIrqEn:   rd_mux = {29'b0, en_q};
            AddrFrame:   rd_mux = frame_cnt_q;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q          <= '0;
            pend_q          <= '0;
            en_q            <= '0;
            frame_cnt_q     <= '0;
            buf_q           <= 1'b0;
            irq_q           <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            ctrl_q          <= ctrl_d;
            pend_q          <= pend_d;
            en_q            <= en_d;
            frame_cnt_q     <= frame_cnt_d;
            buf_q           <= current_buffer_flag;
            irq_q           <= |(pend_q & en_q);
            readdatavalid_q <= do_read;
            if (do_read) readdata_q <= rd_mux;
        end
    end

    assign control_status_out    = ctrl_q;
    assign irq                   = irq_q;
    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = readdatavalid_q;
endmodule
